// File: rtl/key_sched_ctrl.sv
// AES-128 round-key controller: expands one round key per cycle into an 11-entry store with a registered read port.
// Build option KEYSCHED_REVERSE_EN mirrors the read index (addr n -> slot 10-n) for decryption order.
module key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         rk_ready,
  input  logic [3:0]   rk_addr,
  input  logic         rk_rd,
  output logic [127:0] rk_data,
  output logic         rk_valid
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [7:0]   r_rcon;
  logic [127:0] r_prev;
  logic [127:0] r_store [0:10];

  logic         w_accept;
  logic         w_last;
  logic         w_rd_ok;
  logic [3:0]   w_rd_idx;
  logic [127:0] w_step;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254) followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] t;
    logic [31:0] w4;
    logic [31:0] w5;
    logic [31:0] w6;
    logic [31:0] w7;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon, 24'h0};
    w4 = k[127:96] ^ t;
    w5 = w4 ^ k[95:64];
    w6 = w5 ^ k[63:32];
    w7 = w6 ^ k[31:0];
    return {w4, w5, w6, w7};
  endfunction

  assign key_ready = (r_state != EXPAND);
  assign rk_ready  = (r_state == READY);
  assign w_accept  = key_valid & key_ready;
  assign w_last    = (r_cnt == 4'd10);
  assign w_step    = key_step(r_prev, r_rcon);
  assign w_rd_ok   = (r_state == READY) && (rk_addr <= 4'd10);

`ifdef KEYSCHED_REVERSE_EN
  assign w_rd_idx = 4'd10 - rk_addr;
`else
  assign w_rd_idx = rk_addr;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (key_valid) w_state_nxt = EXPAND;
      EXPAND:  if (w_last)    w_state_nxt = READY;
      READY:   if (key_valid) w_state_nxt = EXPAND;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rcon  <= 8'h01;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= 4'd1;
        r_rcon <= 8'h01;
      end else if (r_state == EXPAND) begin
        r_cnt  <= r_cnt + 4'd1;
        r_rcon <= xtime(r_rcon);
      end
    end
  end

  // r_prev mirrors slot[cnt-1] so the shared step never needs a second store read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_accept) begin
        r_store[0] <= key_in;
        r_prev     <= key_in;
      end else if (r_state == EXPAND) begin
        r_store[r_cnt] <= w_step;
        r_prev         <= w_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
    end else if (rk_rd) begin
      rk_valid <= w_rd_ok;
      rk_data  <= w_rd_ok ? r_store[w_rd_idx] : '0;
    end else begin
      rk_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Randomized self-checking bench for key_sched_ctrl against a word-level FIPS-197 key expansion model.
// Honours KEYSCHED_REVERSE_EN for the expected read order.
module tb_key_sched_ctrl;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         rk_ready;
  logic [3:0]   rk_addr;
  logic         rk_rd;
  logic [127:0] rk_data;
  logic         rk_valid;

  key_sched_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .rk_ready  (rk_ready),
    .rk_addr   (rk_addr),
    .rk_rd     (rk_rd),
    .rk_data   (rk_data),
    .rk_valid  (rk_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_chk  = 0;
  int unsigned  n_pass = 0;
  logic [7:0]   sbox_t [0:255];
  logic [7:0]   rcon_t [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [127:0] exp_rk [0:10];
  logic         mdl_ready;
  logic [127:0] mdl_data;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic int slot_of(input int addr);
`ifdef KEYSCHED_REVERSE_EN
    return 10 - addr;
`else
    return addr;
`endif
  endfunction

  // Check the result of a read issued at the previous edge.
  task automatic expect_read(input int addr, input logic ready);
    if (ready && addr <= 10) begin
      mdl_data = exp_rk[slot_of(addr)];
      chk("rd_valid", {127'd0, rk_valid}, 128'd1);
    end else begin
      mdl_data = '0;
      chk("rd_valid", {127'd0, rk_valid}, 128'd0);
    end
    chk("rd_data", rk_data, mdl_data);
  endtask

  task automatic rd(input int addr);
    rk_rd   = 1'b1;
    rk_addr = 4'(addr);
    @(posedge clk);
    @(negedge clk);
    expect_read(addr, mdl_ready);
    rk_rd = 1'b0;
  endtask

  task automatic do_load(input logic [127:0] key, input int abort_at);
    int   addr;
    int   cycles;
    logic aborted;
    addr      = int'($urandom_range(0, 15));
    key_valid = 1'b1;
    key_in    = key;
    rk_rd     = 1'b1;
    rk_addr   = 4'(addr);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    expect_read(addr, mdl_ready);
    chk("rk_ready_drop", {127'd0, rk_ready}, 128'd0);
    chk("key_ready_busy", {127'd0, key_ready}, 128'd0);
    mdl_ready = 1'b0;
    expand(key);
    cycles  = 0;
    aborted = 1'b0;
    while (!rk_ready && cycles < 20 && !aborted) begin
      addr      = int'($urandom_range(0, 15));
      rk_rd     = 1'b1;
      rk_addr   = 4'(addr);
      key_valid = (cycles == 3);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      if (cycles == abort_at) rst = 1'b0;
      @(posedge clk);
      cycles++;
      @(negedge clk);
      key_valid = 1'b0;
      if (!rst) begin
        rst     = 1'b1;
        aborted = 1'b1;
        chk("abort_rk_ready", {127'd0, rk_ready}, 128'd0);
        chk("abort_key_ready", {127'd0, key_ready}, 128'd1);
      end else if (!rk_ready) begin
        chk("expand_key_ready", {127'd0, key_ready}, 128'd0);
      end
      expect_read(addr, 1'b0);
    end
    rk_rd = 1'b0;
    if (!aborted) begin
      chk("load_latency", 128'(cycles), 128'd10);
      mdl_ready = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    build_sbox();
    mdl_ready = 1'b0;
    mdl_data  = '0;
    rst       = 1'b0;
    key_valid = 1'b1;
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    rk_rd     = 1'b1;
    rk_addr   = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_key_ready", {127'd0, key_ready}, 128'd1);
    chk("rst_rk_ready", {127'd0, rk_ready}, 128'd0);
    chk("rst_rk_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_rk_data", rk_data, 128'd0);
    rst       = 1'b1;
    key_valid = 1'b0;
    rk_rd     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_key_ready", {127'd0, key_ready}, 128'd1);
    chk("idle_rk_ready", {127'd0, rk_ready}, 128'd0);
    rd(3);

    do_load(FIPS_KEY, -1);
    rd(slot_of(1));
    chk("fips_rk1", rk_data, FIPS_RK1);
    rd(slot_of(10));
    chk("fips_rk10", rk_data, FIPS_RK10);
    rd(slot_of(0));
    chk("fips_key", rk_data, FIPS_KEY);
    rd(11);
    rd(15);
    for (int i = 0; i < 20; i++) rd(int'($urandom_range(0, 15)));
    rd(int'($urandom_range(0, 10)));
    rk_addr = 4'($urandom_range(0, 15));
    @(posedge clk);
    @(negedge clk);
    chk("hold_valid", {127'd0, rk_valid}, 128'd0);
    chk("hold_data", rk_data, mdl_data);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("ready_persist", {127'd0, rk_ready}, 128'd1);

    do_load(SEQ_KEY, -1);
    rd(slot_of(10));
    chk("seq_rk10", rk_data, SEQ_RK10);
    for (int i = 0; i < 12; i++) rd(int'($urandom_range(0, 15)));

    do_load({$urandom, $urandom, $urandom, $urandom}, 4);
    mdl_data = '0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("abort_stays_idle", {127'd0, rk_ready}, 128'd0);
    rd(int'($urandom_range(0, 10)));
    rd(int'($urandom_range(0, 15)));

    for (int k = 0; k < 3; k++) begin
      do_load({$urandom, $urandom, $urandom, $urandom}, -1);
      for (int i = 0; i < 12; i++) rd(int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequential round-key controller for the AES-128 decryptor. It accepts a 128-bit cipher key and iterates one key-expansion step per cycle, deriving the round constant internally. It stores all 11 round keys in an internal key store and serves any of them to the inverse-round datapath through a registered read port. It sits between the key load interface and the decryption round sequencer.

## Interface
- No parameters; AES-128 fixed (11 round keys, 10 expansion steps).
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `key_valid`  in  1  cipher key offered.
- `key_in`  in  128  cipher key. `[127:120]` is byte 0; `[127:96]` is w0 and `[31:0]` is w3 (column-major).
- `key_ready`  out  1  controller can accept a key. High in IDLE and READY.
- `rk_ready`  out  1  all 11 round keys are stored and valid.
- `rk_addr`  in  4  round-key index requested, 0..10.
- `rk_rd`  in  1  read strobe.
- `rk_data`  out  128  registered round key.
- `rk_valid`  out  1  `rk_data` is valid this cycle.

## Operation
- **States:** IDLE, EXPAND, READY.
- **IDLE → EXPAND** when `key_valid & key_ready`.
  - `key_in` is written to slot 0.
  - Step counter is set to 1; rcon is set to 8'h01.
- **EXPAND**, each cycle:
  - Slot[cnt] = step(slot[cnt-1], rcon).
  - `cnt` increments.
  - rcon updates as xtime: `rcon[7] ? {rcon[6:0],1'b0} ^ 8'h1B : {rcon[6:0],1'b0}`.
  - Rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
- **step(w0..w3, rcon):**
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w4 = w0 ^ t; w5 = w4 ^ w1; w6 = w5 ^ w2; w7 = w6 ^ w3.
  - One combinational step instance is shared by all rounds.
- **EXPAND → READY** on the cycle slot 10 is written (cnt = 10).
- **READY → EXPAND** on a new `key_valid & key_ready`.
  - The new key overwrites slot 0.
  - `rk_ready` drops the cycle after acceptance.
- `key_valid` while in EXPAND is ignored (`key_ready` = 0). It is not queued.
- **Reads** (`rk_rd` sampled at the rising edge):
  - In READY with `rk_addr` ≤ 10: next cycle `rk_data` = slot[addr] and `rk_valid` = 1.
  - With `rk_addr` > 10, or in IDLE/EXPAND: next cycle `rk_data` = 0 and `rk_valid` = 0.
  - With `rk_rd` low: `rk_valid` = 0 next cycle and `rk_data` holds its last value.
- A read in the same cycle as a new key acceptance in READY is served from the old store. The state is still READY at that edge.

## Timing
- **Reset values:** state IDLE, `key_ready` 1, `rk_ready` 0, `rk_valid` 0, `rk_data` 0, cnt 0, rcon 8'h01. The key store is not cleared.
- **Load latency:** key accepted at edge E0; slots 1..10 are written at edges E1..E10. `rk_ready` = 1 and `key_ready` = 1 from after E10, i.e. 10 cycles after acceptance.
- **Read latency:** 1 cycle. Back-to-back reads on consecutive cycles are supported, one result per cycle.
- **Reset mid-EXPAND:** the next edge returns to IDLE with `rk_ready` 0. Partial keys are never reported valid.
- `rk_ready` stays high in READY indefinitely until a new key is accepted or reset.

## Configuration
- **`KEYSCHED_REVERSE_EN`** selects read-index order.
- **Defined:** the read index is mirrored, so `rk_addr` n returns slot[10-n]. Address 0 yields the last round key (first key the decryptor uses); address 10 yields the cipher key. The range check (`rk_addr` > 10 → 0) is unchanged.
- **Undefined:** `rk_addr` n returns slot[n] (encryption order).
- All other behaviour and timing are identical in both builds.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles with `key_valid` = 1 → `key_ready` 1, `rk_ready` 0, `rk_valid` 0, `rk_data` 0; no state change.
- **FIPS-197 expansion:** load key 2b7e151628aed2a6abf7158809cf4f3c → `rk_ready` rises exactly 10 cycles after acceptance. Required values, macro undefined:
  - Read addr 1 → a0fafe1788542cb123a339392a6c7605.
  - Read addr 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Read addr 0 → the key itself.
- **Reverse build:** same key with `KEYSCHED_REVERSE_EN` defined; read addr 0 → d014f9a8c9ee2589e13f0cc8b6630ca6; addr 10 → 2b7e1516...4f3c.
- **Illegal/early reads:** read addr 11 and 15 in READY, and any addr during EXPAND → `rk_data` 0, `rk_valid` 0 the next cycle. `key_valid` pulsed during EXPAND → ignored; final keys match the first key.
- **Reload and abort:**
  - In READY, load key 000102030405060708090a0b0c0d0e0f → `rk_ready` drops next cycle, then after 10 cycles addr 10 (normal order) = 13111d7fe3944a17f307a78b4d2b30c5.
  - Assert `rst` = 0 at cycle 5 of EXPAND → IDLE next edge, `rk_ready` stays 0.
